// File: rtl/mem_bus_if.sv
// Split-handshake SRAM-like data bus: request phase (req/addr_ok), then a response
// phase (data_ok) that carries read data or signals write completion.
interface mem_bus_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [ADDR_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_data_port.sv
// MEM-stage data access unit: turns one load/store into a single bus transaction,
// stalls the pipeline while it is outstanding and drains transactions killed by a flush.
//   state | meaning
//   IDLE  | no access outstanding; a new access issues with zero bubble
//   REQ   | request presented, not yet accepted
//   WAIT  | request accepted, waiting for data_ok
//   DONE  | result held in the buffer until the stage advances
//   ABORT | flushed after acceptance; waiting to swallow the stale data_ok
module mem_data_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_en,
  input  logic [3:0]        m_wen,
  input  logic [1:0]        m_size,
  input  logic [ADDR_W-1:0] m_vaddr,
  input  logic [ADDR_W-1:0] m_wdata,
  input  logic              m_excp,
  input  logic              flush,
  input  logic              mem_adv,
  output logic              stallreq,
  output logic [ADDR_W-1:0] rdata,
  output logic              rdata_vld,
  mem_bus_if.master         bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rbuf_q, rbuf_d;
  logic              start;

  assign start = m_en & ~m_excp & ~flush;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB
  assign bus.addr  = (m_vaddr[31:30] == 2'b10) ? {3'b000, m_vaddr[28:0]} : m_vaddr;
  assign bus.wr    = |m_wen;
  assign bus.size  = m_size;
  assign bus.wstrb = m_wen;
  assign bus.wdata = m_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rbuf_d    = rbuf_q;
    bus.req   = 1'b0;
    stallreq  = 1'b0;
    rdata_vld = 1'b0;
    rdata     = '0;
    // Outputs are forced quiet while reset is held, not just after the state flop clears
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          bus.req  = start;
          stallreq = start;
          if (start) state_d = bus.addr_ok ? WAIT : REQ;
        end
        REQ: begin
          bus.req  = 1'b1;
          stallreq = 1'b1;
          if (bus.addr_ok)  state_d = flush ? ABORT : WAIT;
          else if (flush)   state_d = IDLE;
        end
        WAIT: begin
          stallreq = ~bus.data_ok;
          if (bus.data_ok) begin
            rdata     = bus.rdata;
            rdata_vld = 1'b1;
            rbuf_d    = bus.rdata;
            state_d   = (mem_adv || flush) ? IDLE : DONE;
          end else if (flush) begin
            state_d = ABORT;
          end
        end
        DONE: begin
          rdata     = rbuf_q;
          rdata_vld = 1'b1;
          if (mem_adv || flush) state_d = IDLE;
        end
        ABORT: begin
          stallreq = m_en;
          if (bus.data_ok) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_data_port.md
Name: mem_data_port

Overview:
- Memory-stage data access unit. It sits downstream of the EX/MEM pipeline register and is the consumer end of its memory-request fields (enable, byte write-enables, virtual address, write data).
- Converts each MEM-stage load/store into one transaction on the SRAM-like split-handshake data bus (req/addr_ok, then data_ok).
- Raises a pipeline stall request while the access is outstanding.
- Holds the load result until the stage advances, and safely drains transactions cancelled by a flush.

Parameters:
- ADDR_W, 32, address and data width; fixed at 32, no other value supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m_en  in  1  MEM-stage instruction performs a data access
- m_wen  in  4  byte write enables; nonzero = store, zero = load
- m_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- m_vaddr  in  32  virtual byte address
- m_wdata  in  32  store data, already lane-aligned
- m_excp  in  1  exception already flagged for this instruction; access must not issue
- flush  in  1  pipeline flush this cycle
- mem_adv  in  1  MEM stage captures a new instruction at this edge
- stallreq  out  1  stall request to the pipeline controller
- rdata  out  32  load data, raw 32-bit bus word
- rdata_vld  out  1  rdata valid for the current instruction
- bus_req  out  1  request
- bus_wr  out  1  1 = write
- bus_size  out  2  equals m_size
- bus_addr  out  32  physical address
- bus_wstrb  out  4  equals m_wen
- bus_wdata  out  32  equals m_wdata
- bus_addr_ok  in  1  request accepted
- bus_data_ok  in  1  read data or write completion
- bus_rdata  in  32  read data

Behaviour:
- Reset: asynchronous, active-high on rst; clock clk, rising edge.
  - State = IDLE, result buffer = 0.
  - bus_req = 0, stallreq = 0, rdata_vld = 0, rdata = 0.
- Address map (combinational):
  - vaddr[31:30] == 2'b10 (kseg0/kseg1): bus_addr = {3'b000, vaddr[28:0]}.
  - Otherwise: bus_addr = vaddr.
- start = m_en & ~m_excp & ~flush.
- States: IDLE, REQ, WAIT, DONE, ABORT.
- IDLE:
  - bus_req = start (zero-bubble issue). stallreq = start.
  - If addr_ok and no flush → WAIT. If start and not addr_ok → REQ.
- REQ:
  - bus_req = 1. Address, size, strobe and data track the held stage inputs; these are stable because the stage is stalled.
  - addr_ok & ~flush → WAIT.
  - addr_ok & flush → ABORT.
  - ~addr_ok & flush → IDLE; req is withdrawn and is legal because not yet accepted.
- WAIT:
  - bus_req = 0. stallreq = ~data_ok.
  - On data_ok:
    - rdata = bus_rdata combinationally, rdata_vld = 1, and bus_rdata is captured into the buffer.
    - Next state: mem_adv → IDLE, otherwise DONE.
  - flush & ~data_ok → ABORT.
  - flush & data_ok → IDLE; data is discarded.
- DONE:
  - rdata = buffer, rdata_vld = 1, stallreq = 0, no reissue.
  - mem_adv or flush → IDLE.
- ABORT:
  - bus_req = 0, stallreq = m_en. rdata_vld = 0.
  - data_ok → IDLE; the next access may issue from IDLE in the following cycle.
- Latency and ordering:
  - Minimum access is 2 cycles: addr_ok in the issue cycle, data_ok on the next cycle.
  - data_ok is never expected in the same cycle as addr_ok for the same request.
  - At most one outstanding transaction.
- rdata_vld = 0 in IDLE, REQ, ABORT, and in WAIT without data_ok. rdata = 0 whenever rdata_vld = 0.
- Stores follow the same flow; rdata content is don't-care but rdata_vld still marks completion.
- Reset mid-transaction returns to IDLE immediately. Bus-side recovery is handled by the system reset.

Test Plan:
- Load word at vaddr 0x8000_1004, addr_ok on first cycle, data_ok next cycle with 0xDEADBEEF, mem_adv then:
  - bus_addr = 0x0000_1004, bus_wr = 0.
  - stallreq high for 1 cycle.
  - rdata = 0xDEADBEEF with rdata_vld on the data_ok cycle.
  - State returns to IDLE.
- Store byte, m_wen = 4'b0100, vaddr 0x0040_0002, addr_ok delayed 3 cycles:
  - bus_req held 4 cycles, bus_wstrb = 0100, bus_size = 0, bus_addr = 0x0040_0002.
  - stallreq drops on the data_ok cycle.
- Load completes while mem_adv = 0 for 2 cycles (external stall), then mem_adv:
  - DONE holds rdata and rdata_vld = 1.
  - No second bus_req.
  - IDLE after mem_adv.
- Flush in WAIT before data_ok; next instruction m_en = 1:
  - ABORT state, stallreq = 1, no bus_req until the late data_ok.
  - New request issues the cycle after data_ok.
  - Aborted data never appears with rdata_vld.
- m_en = 1 with m_excp = 1: bus_req = 0, stallreq = 0, rdata_vld = 0.
- Flush in REQ without addr_ok: bus_req drops next cycle, state IDLE, no ABORT.
- rst asserted in WAIT: all outputs 0 asynchronously.
